bkm_ctrl: RTL and testbench
===========================

BKM_CTRL -- requirements
Module: bkm_ctrl

Interface
REQ-001 Parameter W, default 8: datapath word width in bits.
REQ-002 Parameter N, default 8: iterations per operation.
REQ-003 Parameter LOG2N, default 3: width of the iteration index.
REQ-004 clk  in  1  clock; all state changes on posedge clk.
REQ-005 arst  in  1  reset, synchronous, active-high.
REQ-006 start_valid / start_ready  in / out  1 / 1  operation-request handshake.
REQ-007 start_mode  in  1  BKM mode; start_format  in  2  number format. Both are captured on accept.
REQ-008 X0, Y0, u0, v0  in  W each  initial operands, binary two's complement, captured on accept.
REQ-009 step_ena  out  1  enable to the bkm_step stage.
REQ-010 step_n  out  LOG2N  iteration index; step_mode out 1 and step_format out 2 are the registered copies.
REQ-011 step_d_x, step_d_y  out  2 each  selected digits; encoding 00=0, 01=+1, 11=-1.
REQ-012 step_X, step_Y, step_u, step_v  out  W each  current iterate driven to the step stage.
REQ-013 step_X_np1, step_Y_np1, step_u_np1, step_v_np1  in  W each  step-stage results, binary, valid one cycle after step_ena.
REQ-014 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-015 res_X, res_Y, res_u, res_v  out  W each  final iterate.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE and DONE.
- IDLE: start_ready=1.
- start_valid&start_ready -> load operands, n=0, go to ISSUE.
REQ-018 ISSUE SHALL assert step_ena for exactly one cycle and then go to CAPTURE; step_ena SHALL be 0 in every other state.
REQ-019 CAPTURE SHALL register step_*_np1 into the iterate.
- If n==N-1 -> go to DONE.
- Otherwise n<=n+1 -> go to ISSUE.
REQ-020 Digit selection SHALL be a combinational function of the registered u (for d_x) and v (for d_y), using their 3 MSBs:
- 001, 010, 011 -> +1
- 100, 101, 110 -> -1
- 000, 111 -> 0
REQ-021 DONE: res_valid=1; res_* SHALL hold the iterate stable until res_ready=1, then go to IDLE.
REQ-022 Latency SHALL be fixed: start accepted at edge k -> res_valid high from edge k+1+2N.
- Default N=8: edge k+17.
REQ-023 start_ready SHALL be 0 outside IDLE; start_valid while busy SHALL be ignored and SHALL NOT corrupt the in-flight operation.
REQ-024 res_ready and start_valid high in the same DONE cycle: the result SHALL complete, and the new start SHALL be accepted no earlier than the following IDLE cycle.
REQ-025 Iterate arithmetic SHALL use no widening; step_n SHALL never exceed N-1 and SHALL never wrap.
REQ-026 step_* outputs SHALL be register-driven, with no combinational path from any input, except step_d_x/step_d_y, which derive from registers only.

Reset
REQ-027 With arst high at posedge clk:
- state=IDLE, n=0
- every data register 0
- step_ena=0, res_valid=0, busy=0, start_ready=1 (from the following cycle).
REQ-028 arst asserted mid-operation SHALL abort the operation: no res_valid for it, and step_ena=0 from the next cycle.

Configuration
REQ-029 Macro BKM_CTRL_EARLY_EXIT_EN SHALL control early exit.
- Defined: CAPTURE with captured u==0 and v==0 SHALL go to DONE regardless of n; res_valid SHALL then rise the cycle after that CAPTURE.
- Undefined: always exactly N iterations, per REQ-022.

Verification
REQ-030 Basic operation: X0=5, Y0=3, u0=v0=0 at k, res_ready=1, step stage modelled as a 1-cycle pass-through with increment.
- step_ena pulses seen at edges k+1, k+3, ..., k+15.
- step_n sequence 0..7.
- res_valid at k+17.
REQ-031 Digit selection: u=0x20 -> d_x=01; u=0xA0 -> d_x=11; u=0xE0 -> d_x=00; v=0x60 -> d_y=01.
REQ-032 Backpressure: res_ready=0 for 10 cycles after res_valid.
- res_* stable throughout.
- start_valid pulses meanwhile get start_ready=0 and are ignored.
- Handshake completes on res_ready=1.
REQ-033 Reset mid-operation: arst pulse at iteration n=4.
- IDLE next cycle, all outputs 0, busy=0, start_ready=1.
- No res_valid.
REQ-034 Back-to-back: res_ready=1 and start_valid=1 held continuously.
- Second operation accepted in the IDLE cycle following DONE.
- Result spacing 2N+2 = 18 cycles.
REQ-035 BKM_CTRL_EARLY_EXIT_EN defined, step stage returns u=v=0 at iteration n=2.
- res_valid 7 cycles after accept.
- Macro undefined, same stimulus: res_valid at 17 cycles.

Source files
------------

// File: rtl/bkm_ctrl.sv
// bkm_ctrl: iteration controller for a BKM datapath.
// Loads the initial iterate, runs N issue/capture rounds against an external
// bkm_step stage and presents the final iterate through a valid/ready result port.
// Optional build macro: BKM_CTRL_EARLY_EXIT_EN. When it is defined, a capture
// that returns u==0 and v==0 ends the operation early.
module bkm_ctrl #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic             i_start_mode,
  input  logic [1:0]       i_start_format,
  input  logic [W-1:0]     i_X0,
  input  logic [W-1:0]     i_Y0,
  input  logic [W-1:0]     i_u0,
  input  logic [W-1:0]     i_v0,
  output logic             o_step_ena,
  output logic [LOG2N-1:0] o_step_n,
  output logic             o_step_mode,
  output logic [1:0]       o_step_format,
  output logic [1:0]       o_step_d_x,
  output logic [1:0]       o_step_d_y,
  output logic [W-1:0]     o_step_X,
  output logic [W-1:0]     o_step_Y,
  output logic [W-1:0]     o_step_u,
  output logic [W-1:0]     o_step_v,
  input  logic [W-1:0]     i_step_X_np1,
  input  logic [W-1:0]     i_step_Y_np1,
  input  logic [W-1:0]     i_step_u_np1,
  input  logic [W-1:0]     i_step_v_np1,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [W-1:0]     o_res_X,
  output logic [W-1:0]     o_res_Y,
  output logic [W-1:0]     o_res_u,
  output logic [W-1:0]     o_res_v,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] LAST_N = LOG2N'(N - 1);

  state_t           r_state;
  logic [LOG2N-1:0] r_n;
  logic             r_mode;
  logic [1:0]       r_format;
  logic [W-1:0]     r_X;
  logic [W-1:0]     r_Y;
  logic [W-1:0]     r_u;
  logic [W-1:0]     r_v;
  logic             r_step_ena;
  logic             r_start_ready;
  logic             r_res_valid;
  logic             r_busy;

  logic             w_accept;
  logic             w_early;
  logic             w_last;

  // Digit from the three MSBs of a two's complement iterate: 00=0, 01=+1, 11=-1.
  function automatic logic [1:0] digit_sel(input logic [2:0] msb3);
    logic [1:0] d;
    case (msb3)
      3'b001, 3'b010, 3'b011: d = 2'b01;
      3'b100, 3'b101, 3'b110: d = 2'b11;
      default:                d = 2'b00;
    endcase
    return d;
  endfunction

  assign w_accept = i_start_valid && r_start_ready;

`ifdef BKM_CTRL_EARLY_EXIT_EN
  assign w_early = (i_step_u_np1 == {W{1'b0}}) && (i_step_v_np1 == {W{1'b0}});
`else
  assign w_early = 1'b0;
`endif

  // The round counter saturates at N-1, so it is never advanced past LAST_N.
  assign w_last = (r_n == LAST_N) || w_early;

  // Main controller: state, iterate, counter and every registered output.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state       <= S_IDLE;
      r_n           <= {LOG2N{1'b0}};
      r_mode        <= 1'b0;
      r_format      <= 2'b00;
      r_X           <= {W{1'b0}};
      r_Y           <= {W{1'b0}};
      r_u           <= {W{1'b0}};
      r_v           <= {W{1'b0}};
      r_step_ena    <= 1'b0;
      r_start_ready <= 1'b1;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode        <= i_start_mode;
            r_format      <= i_start_format;
            r_X           <= i_X0;
            r_Y           <= i_Y0;
            r_u           <= i_u0;
            r_v           <= i_v0;
            r_n           <= {LOG2N{1'b0}};
            r_step_ena    <= 1'b1;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_step_ena <= 1'b0;
          r_state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_X <= i_step_X_np1;
          r_Y <= i_step_Y_np1;
          r_u <= i_step_u_np1;
          r_v <= i_step_v_np1;
          if (w_last) begin
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_n        <= r_n + LOG2N'(1);
            r_step_ena <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          // A start arriving now is only seen once start_ready returns in IDLE.
          if (i_res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_step_ena    <= 1'b0;
          r_res_valid   <= 1'b0;
          r_start_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_busy        = r_busy;
  assign o_step_ena    = r_step_ena;
  assign o_step_n      = r_n;
  assign o_step_mode   = r_mode;
  assign o_step_format = r_format;
  assign o_step_X      = r_X;
  assign o_step_Y      = r_Y;
  assign o_step_u      = r_u;
  assign o_step_v      = r_v;
  assign o_step_d_x    = digit_sel(r_u[W-1 -: 3]);
  assign o_step_d_y    = digit_sel(r_v[W-1 -: 3]);
  assign o_res_valid   = r_res_valid;
  assign o_res_X       = r_X;
  assign o_res_Y       = r_Y;
  assign o_res_u       = r_u;
  assign o_res_v       = r_v;

endmodule

// File: tb/tb_bkm_ctrl.sv
// tb_bkm_ctrl: scoreboard bench for bkm_ctrl (W=8, N=8). The step stage is a
// one-cycle increment pass-through that can force u=v=0 on round 2.
module tb_bkm_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       i_start_valid = 1'b0;
  logic       o_start_ready;
  logic       i_start_mode = 1'b0;
  logic [1:0] i_start_format = 2'b00;
  logic [7:0] i_X0 = 8'd0, i_Y0 = 8'd0, i_u0 = 8'd0, i_v0 = 8'd0;
  logic       o_step_ena;
  logic [2:0] o_step_n;
  logic       o_step_mode;
  logic [1:0] o_step_format, o_step_d_x, o_step_d_y;
  logic [7:0] o_step_X, o_step_Y, o_step_u, o_step_v;
  logic [7:0] s_X = 8'd0, s_Y = 8'd0, s_u = 8'd0, s_v = 8'd0;
  logic       o_res_valid;
  logic       i_res_ready = 1'b1;
  logic [7:0] o_res_X, o_res_Y, o_res_u, o_res_v;
  logic       o_busy;

  logic       zero_at2 = 1'b0;

  typedef struct {
    logic [7:0] x, y, u, v;
    int lat;
    int iters;
  } exp_t;

  exp_t sb_q[$];
  int   rise_q[$];
  int   acc_q[$];
  int   hs_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // monitor state
  int         acc_edge = 0;
  int         m_n = 0;
  int         ena_cnt = 0;
  int         last_ena_cnt = 0;
  logic [7:0] m_X, m_Y, m_u, m_v, h_X, h_Y, h_u, h_v;
  logic       m_zero = 1'b0, m_mode = 1'b0;
  logic [1:0] m_fmt = 2'b00;
  logic       prev_rv = 1'b0, prev_ena = 1'b0;

  bkm_ctrl #(.W(8), .N(8), .LOG2N(3)) dut (
    .clk(clk), .arst(arst),
    .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
    .i_start_mode(i_start_mode), .i_start_format(i_start_format),
    .i_X0(i_X0), .i_Y0(i_Y0), .i_u0(i_u0), .i_v0(i_v0),
    .o_step_ena(o_step_ena), .o_step_n(o_step_n),
    .o_step_mode(o_step_mode), .o_step_format(o_step_format),
    .o_step_d_x(o_step_d_x), .o_step_d_y(o_step_d_y),
    .o_step_X(o_step_X), .o_step_Y(o_step_Y), .o_step_u(o_step_u), .o_step_v(o_step_v),
    .i_step_X_np1(s_X), .i_step_Y_np1(s_Y), .i_step_u_np1(s_u), .i_step_v_np1(s_v),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_X(o_res_X), .o_res_Y(o_res_Y), .o_res_u(o_res_u), .o_res_v(o_res_v),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Edge counter: value is the number of posedges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Step stage model: one-cycle increment, optionally zeroing u/v on round 2.
  always @(posedge clk) begin
    if (o_step_ena) begin
      s_X <= o_step_X + 8'd1;
      s_Y <= o_step_Y + 8'd1;
      if (zero_at2 && o_step_n == 3'd2) begin
        s_u <= 8'd0;
        s_v <= 8'd0;
      end else begin
        s_u <= o_step_u + 8'd1;
        s_v <= o_step_v + 8'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_digit(input logic [7:0] val);
    logic [1:0] d;
    case (val[7:5])
      3'b001, 3'b010, 3'b011: d = 2'b01;
      3'b100, 3'b101, 3'b110: d = 2'b11;
      default:                d = 2'b00;
    endcase
    return d;
  endfunction

  function automatic exp_t model_op(input logic [7:0] x, input logic [7:0] y,
                                    input logic [7:0] u, input logic [7:0] v, input logic z);
    exp_t r;
    logic stop;
    r.x = x; r.y = y; r.u = u; r.v = v; r.iters = 0; stop = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (!stop) begin
        r.x = r.x + 8'd1;
        r.y = r.y + 8'd1;
        if (z && n == 2) begin
          r.u = 8'd0; r.v = 8'd0;
        end else begin
          r.u = r.u + 8'd1; r.v = r.v + 8'd1;
        end
        r.iters = n + 1;
`ifdef BKM_CTRL_EARLY_EXIT_EN
        if (r.u == 8'd0 && r.v == 8'd0) stop = 1'b1;
`endif
      end
    end
    r.lat = 1 + 2 * r.iters;
    return r;
  endfunction

  // Monitor at the falling edge: values seen here are what the next posedge (cyc+1) samples.
  always @(negedge clk) begin
    int e;
    e = cyc + 1;
    if (arst) begin
      prev_rv  = 1'b0;
      prev_ena = 1'b0;
    end else begin
      if (i_start_valid && o_start_ready) begin
        sb_q.push_back(model_op(i_X0, i_Y0, i_u0, i_v0, zero_at2));
        acc_q.push_back(e);
        acc_edge = e;
        m_X = i_X0; m_Y = i_Y0; m_u = i_u0; m_v = i_v0;
        m_n = 0; ena_cnt = 0; m_zero = zero_at2;
        m_mode = i_start_mode; m_fmt = i_start_format;
      end
      if (o_step_ena) begin
        chk("ena_width", {31'd0, prev_ena}, 32'd0);
        chk("ena_edge", e - acc_edge, 1 + 2 * m_n);
        chk("step_n", {29'd0, o_step_n}, m_n);
        chk("step_X", {24'd0, o_step_X}, {24'd0, m_X});
        chk("step_u", {24'd0, o_step_u}, {24'd0, m_u});
        chk("step_v", {24'd0, o_step_v}, {24'd0, m_v});
        chk("d_x", {30'd0, o_step_d_x}, {30'd0, ref_digit(m_u)});
        chk("d_y", {30'd0, o_step_d_y}, {30'd0, ref_digit(m_v)});
        chk("step_mode", {31'd0, o_step_mode}, {31'd0, m_mode});
        chk("step_fmt", {30'd0, o_step_format}, {30'd0, m_fmt});
        m_X = m_X + 8'd1; m_Y = m_Y + 8'd1;
        if (m_zero && m_n == 2) begin
          m_u = 8'd0; m_v = 8'd0;
        end else begin
          m_u = m_u + 8'd1; m_v = m_v + 8'd1;
        end
        m_n++;
        ena_cnt++;
      end
      if (o_res_valid && !prev_rv) begin
        rise_q.push_back(e);
        h_X = o_res_X; h_Y = o_res_Y; h_u = o_res_u; h_v = o_res_v;
        if (sb_q.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
        else chk("latency", e - acc_edge, sb_q[0].lat);
      end
      if (o_res_valid && prev_rv) begin
        chk("hold_X", {24'd0, o_res_X}, {24'd0, h_X});
        chk("hold_Y", {24'd0, o_res_Y}, {24'd0, h_Y});
        chk("hold_u", {24'd0, o_res_u}, {24'd0, h_u});
        chk("hold_v", {24'd0, o_res_v}, {24'd0, h_v});
      end
      if (o_res_valid && i_res_ready) begin
        hs_q.push_back(e);
        last_ena_cnt = ena_cnt;
        if (sb_q.size() == 0) begin
          chk("res_no_entry", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chk("res_X", {24'd0, o_res_X}, {24'd0, x.x});
          chk("res_Y", {24'd0, o_res_Y}, {24'd0, x.y});
          chk("res_u", {24'd0, o_res_u}, {24'd0, x.u});
          chk("res_v", {24'd0, o_res_v}, {24'd0, x.v});
          chk("ena_count", ena_cnt, x.iters);
        end
      end
      prev_rv  = o_res_valid;
      prev_ena = o_step_ena;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted (bounded), then drop start_valid.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] u,
                          input logic [7:0] v, input logic z);
    int cnt;
    logic acc;
    cnt = 0; acc = 1'b0;
    zero_at2 = z;
    i_X0 = x; i_Y0 = y; i_u0 = u; i_v0 = v;
    i_start_mode = x[0]; i_start_format = y[1:0];
    i_start_valid = 1'b1;
    while (!acc && cnt < 60) begin
      acc = o_start_ready;
      tick();
      cnt++;
    end
    i_start_valid = 1'b0;
    chk("start_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int cnt;
    int seen;
    logic [7:0] bx;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;
    logic [7:0] bx;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", {31'd0, o_start_ready}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_step_ena", {31'd0, o_step_ena}, 32'd0);
    chk("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk("rst_res_X", {24'd0, o_res_X}, 32'd0);
    chk("rst_step_n", {29'd0, o_step_n}, 32'd0);
    arst = 1'b0;
    tick();

    // basic operation
    i_res_ready = 1'b1;
    start_op(8'd5, 8'd3, 8'd0, 8'd0, 1'b0);
    chk("basic_busy", {31'd0, o_busy}, 32'd1);
    chk("basic_sready", {31'd0, o_start_ready}, 32'd0);
    wait_done(60);
    chk("basic_lat", rise_q[rise_q.size()-1] - acc_q[acc_q.size()-1], 32'd17);
    chk("basic_ena_cnt", last_ena_cnt, 32'd8);

    // digit selection, checked on the freshly loaded iterate
    start_op(8'h01, 8'h00, 8'h20, 8'h60, 1'b0);
    chk("dx_20", {30'd0, o_step_d_x}, 32'd1);
    chk("dy_60", {30'd0, o_step_d_y}, 32'd1);
    wait_done(60);
    start_op(8'h7F, 8'h02, 8'hA0, 8'hE0, 1'b0);
    chk("dx_A0", {30'd0, o_step_d_x}, 32'd3);
    chk("dy_E0", {30'd0, o_step_d_y}, 32'd0);
    wait_done(60);
    start_op(8'hFE, 8'h81, 8'hE0, 8'hA0, 1'b0);
    chk("dx_E0", {30'd0, o_step_d_x}, 32'd0);
    chk("dy_A0", {30'd0, o_step_d_y}, 32'd3);
    wait_done(60);

    // backpressure
    i_res_ready = 1'b0;
    start_op(8'h40, 8'hC0, 8'h05, 8'h30, 1'b0);
    cnt = 0;
    while (!o_res_valid && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("bp_valid", {31'd0, o_res_valid}, 32'd1);
    bx = o_res_X;
    for (int i = 0; i < 10; i++) begin
      i_X0 = 8'hAA; i_u0 = 8'h77;
      i_start_valid = (i % 2 == 0);
      tick();
      chk("bp_sready", {31'd0, o_start_ready}, 32'd0);
      chk("bp_valid_hold", {31'd0, o_res_valid}, 32'd1);
      chk("bp_X_stable", {24'd0, o_res_X}, {24'd0, bx});
    end
    i_start_valid = 1'b0;
    tick();
    i_res_ready = 1'b1;
    wait_done(10);
    tick();
    chk("bp_idle", {31'd0, o_start_ready}, 32'd1);
    chk("bp_no_accept", {31'd0, o_busy}, 32'd0);

    // reset mid-operation at round 4
    start_op(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    cnt = 0;
    while (!(o_step_ena && o_step_n == 3'd4) && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("mid_reached_n4", {29'd0, o_step_n}, 32'd4);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    sb_q.delete();
    chk("mid_step_ena", {31'd0, o_step_ena}, 32'd0);
    chk("mid_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_sready", {31'd0, o_start_ready}, 32'd1);
    chk("mid_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk("mid_step_n", {29'd0, o_step_n}, 32'd0);
    chk("mid_step_X", {24'd0, o_step_X}, 32'd0);
    chk("mid_step_u", {24'd0, o_step_u}, 32'd0);
    chk("mid_res_v", {24'd0, o_res_v}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_res_valid) seen++;
    end
    chk("mid_no_res", seen, 32'd0);

    // back-to-back with start_valid and res_ready held high
    rise_q.delete(); acc_q.delete(); hs_q.delete();
    i_res_ready = 1'b1;
    zero_at2 = 1'b0;
    i_X0 = 8'h09; i_Y0 = 8'h90; i_u0 = 8'h08; i_v0 = 8'hF0;
    i_start_valid = 1'b1;
    cnt = 0;
    while (acc_q.size() < 2 && cnt < 100) begin
      tick();
      cnt++;
    end
    i_start_valid = 1'b0;
    wait_done(60);
    chk("b2b_accepts", acc_q.size(), 32'd2);
    if (rise_q.size() >= 2 && acc_q.size() >= 2 && hs_q.size() >= 1) begin
      chk("b2b_spacing", rise_q[1] - rise_q[0], 32'd18);
      chk("b2b_accept_edge", acc_q[1] - hs_q[0], 32'd1);
    end else begin
      chk("b2b_results", rise_q.size(), 32'd2);
    end

    // early exit: the step stage returns u=v=0 on round 2
    start_op(8'h20, 8'h30, 8'h10, 8'h10, 1'b1);
    wait_done(60);
`ifdef BKM_CTRL_EARLY_EXIT_EN
    chk("ee_lat", rise_q[rise_q.size()-1] - acc_q[acc_q.size()-1], 32'd7);
    chk("ee_ena_cnt", last_ena_cnt, 32'd3);
`else
    chk("ee_lat", rise_q[rise_q.size()-1] - acc_q[acc_q.size()-1], 32'd17);
    chk("ee_ena_cnt", last_ena_cnt, 32'd8);
`endif
    zero_at2 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
